// File: rtl/shared_port_sequencer_if.sv
// Memory-side request/ready/rvalid bundle for the shared port sequencer.
// master modport: the sequencer (drives request fields, receives ready/rvalid/rdata).
// slave modport : the memory (receives request fields, drives ready/rvalid/rdata).
interface shared_port_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/shared_port_sequencer.sv
// Shared port sequencer: takes the winner chosen by the read/write priority
// arbiter, runs that one transaction on the single memory port and returns
// ack / read completion / timeout error to the winning master.
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   arb_rd_found/wr_found/winner_id   arbiter result, sampled only in IDLE
//   m_addr, m_wdata      packed per-master request fields
//   arb_en               high while IDLE (arbiter result is being sampled)
//   m_ack                one-cycle accept pulse to the winner
//   m_rvalid, m_err      one-cycle read completion, err marks a timeout
//   m_rdata              shared read data, holds between completions
//   mem                  memory-side request/ready/rvalid bundle
//   busy                 transaction in flight
module shared_port_sequencer #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RSP_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          arb_rd_found,
   input  logic                          arb_wr_found,
   input  logic [$clog2(NUM_MASTERS)-1:0] arb_winner_id,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   output logic                          arb_en,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [DATA_W-1:0]             m_rdata,
   shared_port_sequencer_if.master       mem,
   output logic                          busy
);

   localparam int ID_W    = $clog2(NUM_MASTERS);
   localparam int CNT_W   = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
   // Last counter value before the timeout fires; the error is issued from
   // the RSP_TIMEOUT-th WAIT_RD cycle without data.
   localparam int TO_LAST = (RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0;
   localparam logic [ID_W:0] NM_LIM = NUM_MASTERS[ID_W:0];

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t                   state_q, state_d;
   logic [ID_W-1:0]          id_q, id_d;
   logic                     we_q, we_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0]   ack_q, ack_d;
   logic [NUM_MASTERS-1:0]   rvalid_q, rvalid_d;
   logic [NUM_MASTERS-1:0]   err_q, err_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d;
   logic                     mem_req_q, mem_req_d;
   logic                     arb_en_q, arb_en_d;

   logic [ADDR_W-1:0]        sel_addr;
   logic [DATA_W-1:0]        sel_wdata;
   logic                     id_ok;

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NUM_MASTERS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (id == ID_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Compare-based select keeps an out-of-range id from indexing past the bus.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (arb_winner_id == ID_W'(i)) begin
            sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = m_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign id_ok = ({1'b0, arb_winner_id} < NM_LIM);

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      rvalid_d  = '0;
      err_d     = '0;
      rdata_d   = rdata_q;
      mem_req_d = mem_req_q;
      case (state_q)
         IDLE: begin
            if ((arb_rd_found || arb_wr_found) && id_ok) begin
               state_d   = ISSUE;
               id_d      = arb_winner_id;
               we_d      = ~arb_rd_found;   // read wins when both are flagged
               addr_d    = sel_addr;
               wdata_d   = sel_wdata;
               ack_d     = onehot(arb_winner_id);
               mem_req_d = 1'b1;
            end
         end
         ISSUE: begin
            if (mem.mem_ready) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               if (we_q) begin
                  state_d = IDLE;
               end else if (mem.mem_rvalid) begin
                  // zero-latency read: complete without visiting WAIT_RD
                  state_d  = IDLE;
                  rvalid_d = onehot(id_q);
                  rdata_d  = mem.mem_rdata;
               end else begin
                  state_d = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (mem.mem_rvalid) begin
               // data beats a same-cycle timeout
               state_d  = IDLE;
               rvalid_d = onehot(id_q);
               rdata_d  = mem.mem_rdata;
            end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
               state_d  = IDLE;
               rvalid_d = onehot(id_q);
               err_d    = onehot(id_q);
               rdata_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      arb_en_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         id_q      <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         rvalid_q  <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
         mem_req_q <= 1'b0;
         arb_en_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         mem_req_q <= mem_req_d;
         arb_en_q  <= arb_en_d;
      end
   end

   assign arb_en        = arb_en_q;
   assign busy          = ~arb_en_q;
   assign m_ack         = ack_q;
   assign m_rvalid      = rvalid_q;
   assign m_err         = err_q;
   assign m_rdata       = rdata_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_shared_port_sequencer.sv
// Bench for shared_port_sequencer: directed scenarios plus randomized
// back-to-back traffic, checked against a transaction-level timing model.
module tb_shared_port_sequencer;
   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              arst;
   logic              arb_rd_found, arb_wr_found;
   logic [1:0]        arb_winner_id;
   logic [NM*AW-1:0]  m_addr;
   logic [NM*DW-1:0]  m_wdata;
   logic              arb_en, busy;
   logic [NM-1:0]     m_ack, m_rvalid, m_err;
   logic [DW-1:0]     m_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_rdata;

   shared_port_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   shared_port_sequencer #(
      .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RSP_TIMEOUT(TO)
   ) dut (
      .clk(clk), .arst(arst),
      .arb_rd_found(arb_rd_found), .arb_wr_found(arb_wr_found),
      .arb_winner_id(arb_winner_id),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .arb_en(arb_en), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_err(m_err),
      .m_rdata(m_rdata), .mem(mem_if), .busy(busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      logic [110:0] act, expv;
      arst = 1'b1;
      arb_rd_found = 1'b0; arb_wr_found = 1'b0; arb_winner_id = '0;
      m_addr = '0; m_wdata = '0;
      mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
      repeat (3) @(negedge clk);
      act  = {arb_en, busy, m_ack, m_rvalid, m_err, m_rdata, mem_if.mem_req,
              mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
      expv = {1'b1, 1'b0, 9'b0, 32'b0, 2'b0, 64'b0};
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h exp %h", act, expv);
      end
      arst = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      n_cmp++;
      if ({arb_en, busy, mem_if.mem_req} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_release_idle: got %b exp 100", {arb_en, busy, mem_if.mem_req});
      end
   endtask

   // One transaction. rdy_dly = stalled ISSUE cycles before mem_ready;
   // rv_dly: 0 = rvalid with ready, k>0 = rvalid in WAIT_RD cycle k, <0 = never.
   task automatic do_txn(input int id, input logic rdf, input logic wrf,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int rdy_dly, input int rv_dly,
                         input logic [DW-1:0] rd_data);
      logic [NM-1:0] oh;
      logic [108:0]  act, expv;
      logic [DW-1:0] exp_data;
      logic          exp_e;
      int            exp_n;
      int            n;
      bit            seen;
      oh = 3'b001 << id;
      for (int k = 0; k < 50 && arb_en !== 1'b1; k++) @(negedge clk);
      n_cmp++;
      if (arb_en !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_wait: arb_en got %b exp 1", arb_en);
      end
      m_addr  = {$urandom(), $urandom(), $urandom()};
      m_wdata = {$urandom(), $urandom(), $urandom()};
      m_addr[id*AW +: AW]  = addr;
      m_wdata[id*DW +: DW] = wd;
      arb_rd_found = rdf; arb_wr_found = wrf; arb_winner_id = 2'(id);
      @(negedge clk);
      act  = {m_ack, m_rvalid, m_err, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr,
              mem_if.mem_wdata, busy, arb_en, m_rdata};
      expv = {oh, 3'b0, 3'b0, 1'b1, ~rdf, addr, wd, 1'b1, 1'b0, exp_rdata};
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL issue_first id=%0d: got %h exp %h", id, act, expv);
      end
      // Master has been acked; its fields and the arbiter may now change freely.
      m_addr  = {$urandom(), $urandom(), $urandom()};
      m_wdata = {$urandom(), $urandom(), $urandom()};
      arb_rd_found = 1'($urandom_range(0, 1));
      arb_wr_found = 1'($urandom_range(0, 1));
      arb_winner_id = 2'($urandom_range(0, 2));
      for (int k = 0; k < rdy_dly; k++) begin
         mem_if.mem_ready = 1'b0;
         @(negedge clk);
         act  = {m_ack, m_rvalid, m_err, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr,
                 mem_if.mem_wdata, busy, arb_en, m_rdata};
         expv = {3'b0, 3'b0, 3'b0, 1'b1, ~rdf, addr, wd, 1'b1, 1'b0, exp_rdata};
         n_cmp++;
         if (act !== expv) begin
            n_bad++;
            $display("FAIL issue_hold id=%0d cyc=%0d: got %h exp %h", id, k + 1, act, expv);
         end
      end
      arb_rd_found = 1'b0; arb_wr_found = 1'b0;
      mem_if.mem_ready  = 1'b1;
      mem_if.mem_rvalid = rdf && (rv_dly == 0);
      mem_if.mem_rdata  = rd_data;
      @(negedge clk);
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      if (!rdf) begin
         n_cmp++;
         if ({busy, arb_en, mem_if.mem_req, m_rvalid, m_err} !== {3'b010, 6'b0}) begin
            n_bad++;
            $display("FAIL write_done: got %b exp 010000000",
                     {busy, arb_en, mem_if.mem_req, m_rvalid, m_err});
         end
         // Stray rvalid while idle must produce nothing and leave m_rdata alone.
         mem_if.mem_rvalid = 1'b1;
         mem_if.mem_rdata  = $urandom();
         @(negedge clk);
         mem_if.mem_rvalid = 1'b0;
         n_cmp++;
         if ({m_rvalid, m_err, busy, m_rdata} !== {6'b0, 1'b0, exp_rdata}) begin
            n_bad++;
            $display("FAIL stray_rvalid: got %h exp %h", {m_rvalid, m_err, busy, m_rdata},
                     {6'b0, 1'b0, exp_rdata});
         end
      end else begin
         if (rv_dly >= 0 && rv_dly <= TO) begin
            exp_n = rv_dly; exp_e = 1'b0; exp_data = rd_data;
         end else begin
            exp_n = TO; exp_e = 1'b1; exp_data = '0;
         end
         seen = 1'b0;
         for (n = 0; n < 20; n++) begin
            if (m_rvalid !== 3'b000) begin
               seen = 1'b1;
               break;
            end
            mem_if.mem_rvalid = (rv_dly >= 1) && (n == rv_dly - 1);
            mem_if.mem_rdata  = mem_if.mem_rvalid ? rd_data : DW'($urandom());
            @(negedge clk);
         end
         mem_if.mem_rvalid = 1'b0;
         n_cmp++;
         if (!seen || n != exp_n) begin
            n_bad++;
            $display("FAIL rd_latency id=%0d: got %0d cycles (seen=%0d) exp %0d", id, n, seen, exp_n);
         end
         n_cmp++;
         if ({m_rvalid, m_err, m_rdata, busy, arb_en} !== {oh, exp_e ? oh : 3'b0, exp_data, 2'b01}) begin
            n_bad++;
            $display("FAIL rd_complete id=%0d: got %h exp %h", id,
                     {m_rvalid, m_err, m_rdata, busy, arb_en},
                     {oh, exp_e ? oh : 3'b0, exp_data, 2'b01});
         end
         exp_rdata = exp_data;
      end
   endtask

   task automatic test_single_read;
      do_txn(1, 1'b1, 1'b0, 32'h100, $urandom(), 0, 1, 32'hDEADBEEF);
   endtask

   task automatic test_write_backpressure;
      do_txn(0, 1'b0, 1'b1, 32'h40, 32'h55, 3, -1, '0);
   endtask

   task automatic test_contention;
      do_txn(1, 1'b1, 1'b1, 32'h1100, 32'hAAAA0001, 1, 2, 32'hC0FFEE01);
      do_txn(0, 1'b0, 1'b1, 32'h0040, 32'h00000055, 0, -1, '0);
   endtask

   task automatic test_timeout;
      do_txn(2, 1'b1, 1'b0, 32'h300, $urandom(), 0, -1, 32'h11111111);
      do_txn(0, 1'b1, 1'b0, 32'h304, $urandom(), 1, TO, 32'h22222222);
      do_txn(1, 1'b1, 1'b0, 32'h308, $urandom(), 0, TO + 1, 32'h33333333);
   endtask

   task automatic test_zero_latency;
      do_txn(1, 1'b1, 1'b0, 32'h500, $urandom(), 1, 0, 32'h1234);
   endtask

   task automatic test_invalid_id;
      arb_rd_found = 1'b1; arb_winner_id = 2'd3;
      @(negedge clk);
      arb_rd_found = 1'b0; arb_winner_id = 2'd0;
      n_cmp++;
      if ({busy, mem_if.mem_req, m_ack} !== 5'b0) begin
         n_bad++;
         $display("FAIL invalid_id: got %b exp 00000", {busy, mem_if.mem_req, m_ack});
      end
   endtask

   task automatic test_reset_mid;
      // reset while waiting for read data
      m_addr[1*AW +: AW] = 32'h200;
      arb_rd_found = 1'b1; arb_winner_id = 2'd1;
      @(negedge clk);
      arb_rd_found = 1'b0;
      mem_if.mem_ready = 1'b1;
      @(negedge clk);
      mem_if.mem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL wait_rd_busy: got %b exp 1", busy);
      end
      arst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, arb_en, mem_if.mem_req, m_ack, m_rvalid, m_err} !== {3'b010, 9'b0}) begin
         n_bad++;
         $display("FAIL reset_mid_read: got %b exp 010000000000",
                  {busy, arb_en, mem_if.mem_req, m_ack, m_rvalid, m_err});
      end
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      n_cmp++;
      if ({m_rvalid, m_err} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_no_rvalid: got %b exp 000000", {m_rvalid, m_err});
      end
      mem_if.mem_rvalid = 1'b0;
      arst = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      // reset while the request is on the bus
      arb_wr_found = 1'b1; arb_winner_id = 2'd0;
      @(negedge clk);
      arb_wr_found = 1'b0;
      n_cmp++;
      if (mem_if.mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL issue_before_reset: mem_req got %b exp 1", mem_if.mem_req);
      end
      arst = 1'b1;
      #1;
      n_cmp++;
      if ({mem_if.mem_req, busy, m_ack} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_mid_issue: got %b exp 00000", {mem_if.mem_req, busy, m_ack});
      end
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({mem_if.mem_req, busy, m_ack, m_rdata} !== 37'b0) begin
         n_bad++;
         $display("FAIL reset_release: got %h exp 0", {mem_if.mem_req, busy, m_ack, m_rdata});
      end
      do_txn(2, 1'b1, 1'b0, 32'h600, $urandom(), 1, 2, 32'h600D600D);
   endtask

   task automatic test_back_to_back;
      logic rd, wr;
      for (int t = 0; t < 30; t++) begin
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         do_txn($urandom_range(0, NM - 1), rd, wr, $urandom(), $urandom(),
                $urandom_range(0, 3), int'($urandom_range(0, 6)) - 1, $urandom());
      end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_write_backpressure;
      test_contention;
      test_timeout;
      test_zero_latency;
      test_invalid_id;
      test_reset_mid;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
